// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port 256x8 data memory between the core (0)
// and the block loader (1), with a bounded lock for back-to-back bursts.
module dmem_arbiter #(
  parameter int MAX_LOCK = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Req0,
  input  logic       Req1,
  input  logic       We0,
  input  logic       We1,
  input  logic       Lock0,
  input  logic       Lock1,
  input  logic [7:0] Addr0,
  input  logic [7:0] Addr1,
  input  logic [7:0] Wdata0,
  input  logic [7:0] Wdata1,
  output logic       Gnt0,
  output logic       Gnt1,
  output logic [7:0] Rdata0,
  output logic [7:0] Rdata1,
  output logic       Rvalid0,
  output logic       Rvalid1,
  output logic       MemWriteEn,
  output logic [7:0] MemAddress,
  output logic [7:0] MemDataIn,
  input  logic [7:0] MemDataOut,
  output logic       Busy
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  localparam logic [7:0] LOCK_LAST = 8'(MAX_LOCK - 1);
  localparam bit         LOCK_EN   = (MAX_LOCK > 1);

  state_e     state_q, state_d;
  logic       last_gnt_q, last_gnt_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic [7:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic       rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;

  logic       gnt0, gnt1, granted, g_lock;

  // In IDLE a contended cycle goes to whoever was not granted last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (Reset) begin
      case (state_q)
        IDLE: begin
          gnt0 = Req0 && (!Req1 || last_gnt_q);
          gnt1 = Req1 && (!Req0 || !last_gnt_q);
        end
        OWN0:    gnt0 = Req0;
        OWN1:    gnt1 = Req1;
        default: ;
      endcase
    end
  end

  assign granted = gnt0 || gnt1;
  assign g_lock  = gnt1 ? Lock1 : (gnt0 && Lock0);

  always_comb begin
    MemWriteEn = 1'b0;
    MemAddress = 8'h00;
    MemDataIn  = 8'h00;
    if (gnt0) begin
      MemWriteEn = We0;
      MemAddress = Addr0;
      MemDataIn  = Wdata0;
    end else if (gnt1) begin
      MemWriteEn = We1;
      MemAddress = Addr1;
      MemDataIn  = Wdata1;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    last_gnt_d = last_gnt_q;
    if (gnt0) last_gnt_d = 1'b0;
    else if (gnt1) last_gnt_d = 1'b1;

    rvalid0_d = gnt0 && !We0;
    rvalid1_d = gnt1 && !We1;
    rdata0_d  = rvalid0_d ? MemDataOut : rdata0_q;
    rdata1_d  = rvalid1_d ? MemDataOut : rdata1_q;

    case (state_q)
      IDLE: begin
        lock_cnt_d = 8'd0;
        if (granted && g_lock && LOCK_EN) begin
          state_d    = gnt1 ? OWN1 : OWN0;
          lock_cnt_d = 8'd1;
        end
      end
      default: begin
        // A dropped request, an unlocked beat or an exhausted budget all release.
        if (!granted || !g_lock || (lock_cnt_q == LOCK_LAST)) begin
          state_d    = IDLE;
          lock_cnt_d = 8'd0;
        end else begin
          lock_cnt_d = lock_cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      lock_cnt_q <= 8'd0;
      rdata0_q   <= 8'h00;
      rdata1_q   <= 8'h00;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  assign Gnt0    = gnt0;
  assign Gnt1    = gnt1;
  assign Rdata0  = rdata0_q;
  assign Rdata1  = rdata1_q;
  assign Rvalid0 = rvalid0_q;
  assign Rvalid1 = rvalid1_q;
  assign Busy    = (state_q != IDLE);

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port 256x8 data memory between the CPU core (requester 0) and a block loader/DMA engine (requester 1). It sits between both masters and the memory's WriteEn/DataAddress/DataIn/DataOut port. Grants are round-robin, with an optional bounded lock for back-to-back bursts. Read data is registered per requester.

## Interface
- MAX_LOCK, 16: maximum consecutive granted beats a locked owner may hold the memory (1..255).
- Clk  input  1  system clock; all state changes on posedge.
- Reset  input  1  synchronous, active-low; 0 at a posedge resets all state.
- Req0 / Req1  input  1  access request from requester 0 (core) / 1 (loader).
- We0 / We1  input  1  1 = write, 0 = read; sampled only while granted.
- Lock0 / Lock1  input  1  request to keep ownership after this beat.
- Addr0 / Addr1  input  8  byte address.
- Wdata0 / Wdata1  input  8  write data.
- Gnt0 / Gnt1  output  1  combinational grant; the access completes in the cycle Gnt is high.
- Rdata0 / Rdata1  output  8  registered read data of that requester's last granted read.
- Rvalid0 / Rvalid1  output  1  one-cycle pulse, cycle after a granted read.
- MemWriteEn  output  1  to memory WriteEn.
- MemAddress  output  8  to memory DataAddress.
- MemDataIn  output  8  to memory DataIn.
- MemDataOut  input  8  from memory DataOut (combinational read).
- Busy  output  1  1 while in a locked state (OWN0/OWN1).

## Operation
- States: IDLE, OWN0, OWN1. Reset state IDLE.
- IDLE: only Req0 -> Gnt0; only Req1 -> Gnt1; both -> grant the requester opposite LastGnt; neither -> no grant.
- LastGnt register updated to the index of every granted beat; reset value 1, so requester 0 wins the first contended cycle.
- Granted beat with its Lock=1 -> next state OWNx (x = granted index), lock counter loaded with 1.
- OWNx: only requester x may be granted; the other is held off even if requesting.
  - Granted beat with Lock=0 -> IDLE.
  - Reqx=0 -> no grant that cycle, return to IDLE (release).
  - Granted beat with Lock=1 while counter = MAX_LOCK-1 -> forced IDLE regardless of Lock; counter cleared.
  - Otherwise counter increments per granted beat.
- Lock ignored on an ungranted cycle.
- Memory mux: granted x drives MemAddress=Addrx, MemDataIn=Wdatax, MemWriteEn=Wex. No grant -> MemWriteEn=0, MemAddress=0, MemDataIn=0.
- Granted read (Wex=0): Rdatax <= MemDataOut at that posedge; Rvalidx=1 the next cycle only. Rdata holds its value until the next granted read by the same requester. Granted writes leave Rdata unchanged and do not pulse Rvalid.
- At most one of Gnt0/Gnt1 high in any cycle.
- Busy = (state != IDLE).

## Timing
- Grant: same cycle as Req (combinational from state, LastGnt, Req0/Req1). Write lands at the posedge ending the granted cycle.
- Read latency: Rdata/Rvalid valid one cycle after the granted cycle.
- Requester must hold Req/We/Addr/Wdata stable until it sees Gnt. Deasserting Req before grant is legal: the request is dropped, with no side effect.
- Reset=0 forces Gnt0=Gnt1=0, MemWriteEn=0 combinationally. At the posedge: state=IDLE, LastGnt=1, counter=0, Rdata0=Rdata1=0, Rvalid0=Rvalid1=0.
- Reset mid-burst: lock is abandoned with no write in the reset cycle. The first post-reset contended cycle grants requester 0.
- Back-to-back: one beat per cycle sustained by a single requester. Under continuous contention without Lock, grants alternate 0,1,0,1.

## Test plan
- Reset then Req0 read Addr0=8'h82 (memory holds 8'h60) -> Gnt0 same cycle, next cycle Rvalid0=1, Rdata0=8'h60. Rdata1 stays 0.
- Req0 and Req1 asserted together for 4 cycles, both Lock=0 -> grants 0,1,0,1; Busy stays 0; never both grants high.
- Req1 write burst: Lock1=1, addresses 8'h10..8'h13, data 8'hA0..8'hA3, last beat Lock1=0, while Req0 held high -> Gnt1 for 4 cycles, Gnt0 low throughout. Gnt0 high the cycle after release. Readback returns A0..A3.
- MAX_LOCK=16, Req0 with Lock0=1 held 20 cycles plus Req1 high -> Gnt0 for beats 1-16, then IDLE arbitration gives Gnt1 (LastGnt=0).
- Locked owner Req0 drops Req0 mid-burst -> that cycle no grant and MemWriteEn=0; next cycle Req1 is granted.
- Reset driven low during an OWN1 burst write -> MemWriteEn=0 that cycle, target address unchanged. After release, state is IDLE, Busy=0, and a contended cycle grants requester 0.
